// File: rtl/eq_ctrl_pkg.sv
// Shared encodings for the adaptive equalizer sequencer: FSM states, step gears, helpers.
package eq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_ACQ   = 3'd2,
        ST_ACQ2  = 3'd3,
        ST_TRACK = 3'd4,
        ST_HOLD  = 3'd5
    } eq_state_t;

    localparam logic [1:0] STEP_LARGE = 2'd0;
    localparam logic [1:0] STEP_MED   = 2'd1;
    localparam logic [1:0] STEP_SMALL = 2'd2;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) width = i + 1;
        end
        return width;
    endfunction

    function automatic logic [1:0] step_for_state(input eq_state_t s);
        case (s)
            ST_ACQ2:           return STEP_MED;
            ST_TRACK, ST_HOLD: return STEP_SMALL;
            default:           return STEP_LARGE;
        endcase
    endfunction

endpackage

// File: rtl/eq_strobe_gen.sv
// Phase counter, sampling-phase latch and registered T/2 and T strobes for the equalizer.
module eq_strobe_gen
    import eq_ctrl_pkg::*;
#(
    parameter int OS_FACTOR = 4,
    parameter int NB_CNT    = clog2(OS_FACTOR)
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_idle,
    input  logic              i_run,
    input  logic [NB_CNT-1:0] i_phase,
    output logic              o_rate1_cond,
    output logic              o_en_rate2,
    output logic              o_en_rate1
);

    localparam logic [NB_CNT-1:0] PH_MAX  = NB_CNT'(OS_FACTOR - 1);
    localparam logic [NB_CNT-1:0] PH_HALF = NB_CNT'(OS_FACTOR / 2);
    localparam logic [NB_CNT:0]   PH_LIM  = (NB_CNT + 1)'(OS_FACTOR);

    logic [NB_CNT-1:0] cnt;
    logic [NB_CNT-1:0] phase_q;
    logic [NB_CNT-1:0] phase_sat;
    logic [NB_CNT-1:0] phase_half;
    logic              rate2_cond;

    // Out-of-range phases clamp to the last sample of the symbol.
    always_comb begin
        phase_sat    = ({1'b0, i_phase} >= PH_LIM) ? PH_MAX : i_phase;
        phase_half   = (phase_q >= PH_HALF) ? (phase_q - PH_HALF) : (phase_q + PH_HALF);
        o_rate1_cond = i_run && (cnt == phase_q);
        rate2_cond   = i_run && ((cnt == phase_q) || (cnt == phase_half));
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            cnt        <= '0;
            phase_q    <= '0;
            o_en_rate1 <= 1'b0;
            o_en_rate2 <= 1'b0;
        end else begin
            if (i_idle) begin
                cnt     <= '0;
                phase_q <= phase_sat;
            end else begin
                cnt <= (cnt == PH_MAX) ? '0 : cnt + 1'b1;
            end
            o_en_rate1 <= o_rate1_cond;
            o_en_rate2 <= rate2_cond;
        end
    end

endmodule

// File: rtl/adaptive_eq_ctrl.sv
// Start-up and adaptation sequencer for the fractionally spaced LMS equalizer.
// Optional second acquisition gear: define ADAPTIVE_EQ_CTRL_GEAR_SHIFT_EN.
//
// state | meaning
// IDLE  | stopped, phase latch tracks i_phase, no strobes
// FLUSH | filter fills, taps not adapted
// ACQ   | fast acquisition, large step
// ACQ2  | second acquisition gear, medium step
// TRACK | steady-state tracking, small step
// HOLD  | taps frozen, filtering continues
module adaptive_eq_ctrl
    import eq_ctrl_pkg::*;
#(
    parameter int OS_FACTOR  = 4,
    parameter int NB_CNT     = clog2(OS_FACTOR),
    parameter int NB_SYM     = 16,
    parameter int FLUSH_SYMS = 9,
    parameter int ACQ_SYMS   = 2048,
    parameter int ACQ2_SYMS  = 4096
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_freeze,
    input  logic [NB_CNT-1:0] i_phase,
    output logic              o_en_rate2,
    output logic              o_en_rate1,
    output logic              o_save_shtrs,
    output logic              o_en_taps,
    output logic [1:0]        o_step_sel,
    output logic [2:0]        o_state,
    output logic [NB_SYM-1:0] o_sym_cnt
);

    localparam logic [NB_SYM-1:0] FLUSH_LAST = NB_SYM'(FLUSH_SYMS - 1);
    localparam logic [NB_SYM-1:0] ACQ_LAST   = NB_SYM'(ACQ_SYMS - 1);
    localparam logic [NB_SYM-1:0] ACQ2_LAST  = NB_SYM'(ACQ2_SYMS - 1);
`ifdef ADAPTIVE_EQ_CTRL_GEAR_SHIFT_EN
    localparam eq_state_t ACQ_EXIT = ST_ACQ2;
`else
    localparam eq_state_t ACQ_EXIT = ST_TRACK;
`endif

    eq_state_t state;
    eq_state_t state_nxt;
    logic      rate1_cond;

    eq_strobe_gen #(
        .OS_FACTOR (OS_FACTOR),
        .NB_CNT    (NB_CNT)
    ) u_strobe_gen (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_idle       (state == ST_IDLE),
        .i_run        ((state != ST_IDLE) && i_enable),
        .i_phase      (i_phase),
        .o_rate1_cond (rate1_cond),
        .o_en_rate2   (o_en_rate2),
        .o_en_rate1   (o_en_rate1)
    );

    // Freeze is deliberately not honoured in FLUSH so the delay line always fills.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (i_enable) state_nxt = ST_FLUSH;
            ST_FLUSH: if (rate1_cond && (o_sym_cnt == FLUSH_LAST)) state_nxt = ST_ACQ;
            ST_ACQ: begin
                if (i_freeze) state_nxt = ST_HOLD;
                else if (rate1_cond && (o_sym_cnt == ACQ_LAST)) state_nxt = ACQ_EXIT;
            end
            ST_ACQ2: begin
                if (i_freeze) state_nxt = ST_HOLD;
                else if (rate1_cond && (o_sym_cnt == ACQ2_LAST)) state_nxt = ST_TRACK;
            end
            ST_TRACK: if (i_freeze) state_nxt = ST_HOLD;
            ST_HOLD:  if (!i_freeze) state_nxt = ST_TRACK;
            default:  state_nxt = ST_IDLE;
        endcase
        if (!i_enable) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            o_step_sel <= STEP_LARGE;
            o_sym_cnt  <= '0;
            o_en_taps  <= 1'b0;
        end else begin
            state      <= state_nxt;
            o_step_sel <= step_for_state(state_nxt);
            if (state_nxt != state) o_sym_cnt <= '0;
            else if (rate1_cond)    o_sym_cnt <= o_sym_cnt + 1'b1;
            o_en_taps  <= rate1_cond && (state inside {ST_ACQ, ST_ACQ2, ST_TRACK});
        end
    end

    assign o_state      = state;
    assign o_save_shtrs = o_en_rate1;

endmodule
